ysyx_22050133_ifetch_resp: RTL
==============================

// Module: ysyx_22050133_ifetch_resp
// PURPOSE
//   Instruction-fetch responder: the memory end of the IFU pc handshake. Accepts a fetch pc
//   (pc_valid_i/pc_ready_o), issues one 64-bit aligned read on a req/ack memory port and
//   returns the fetched doubleword as inst64_o with the addressed 32-bit word in [31:0].
//   Sits between the IFU and the instruction memory or bus bridge. Handles redirect flush.
// PARAMETERS
//   RESET_PC  64'h8000_0000  pc reported on pc_q_o after reset (debug only)
// PORTS
//   clk          in   1   clock; all state updates on posedge
//   rst          in   1   synchronous, active-high reset
//   pc_valid_i   in   1   IFU presents a fetch pc
//   pc_i         in   64  fetch address
//   pc_ready_o   out  1   responder accepts pc this cycle
//   flush_i      in   1   redirect: discard the in-flight or held fetch
//   fence_i_i    in   1   invalidate the line buffer (ignored without IFETCH_LINEBUF_EN)
//   mem_req_o    out  1   read request, held until mem_ack_i
//   mem_addr_o   out  64  {pc_q[63:3],3'b000}
//   mem_ack_i    in   1   read data valid this cycle
//   mem_rdata_i  in   64  read data
//   inst_valid_o out  1   inst64_o/fault_o valid
//   inst_ready_i in   1   consumer takes the response
//   inst64_o     out  64  pc_q[2] ? {rdata[31:0],rdata[63:32]} : rdata
//   fault_o      out  1   misaligned pc (pc_q[1:0]!=0); inst64_o = 0
//   pc_q_o       out  64  pc of the current or held fetch
// BEHAVIOUR
//   States: IDLE, REQ, DRAIN, RESP. Reset: IDLE. Outputs are 0 except pc_q_o = RESET_PC.
//   pc_ready_o = (state==IDLE) & ~flush_i. Accepting a pc at cycle T latches pc_q.
//   IDLE->REQ: on accept with pc_i[1:0]==0. mem_req_o=1 from T+1.
//   IDLE->RESP: on accept with a misaligned pc. fault_o=1 and no memory access.
//   REQ: mem_req_o and mem_addr_o are stable until mem_ack_i.
//     On mem_ack_i: latch rdata and go to RESP.
//     With an ack in T+1, inst_valid_o rises at T+2.
//   RESP: inst_valid_o=1. inst64_o, fault_o and pc_q_o are stable until inst_ready_i.
//     On inst_ready_i: go to IDLE. A new pc can be accepted the following cycle.
//   Flush:
//     in IDLE: no accept that cycle.
//     in REQ without ack: go to DRAIN.
//     in REQ with ack in the same cycle: data dropped, go to IDLE.
//     in RESP: response dropped even if inst_ready_i is high. inst_valid_o=0 next cycle. Go to IDLE.
//   DRAIN: mem_req_o stays 1 (request is already committed). On mem_ack_i the data is discarded -> IDLE.
//     inst_valid_o is never raised for a flushed fetch.
//   The response holds while inst_ready_i=0. No timeout.
//   rst mid-transaction: return to IDLE immediately and drop any pending ack.
//     The memory side must tolerate an abandoned request.
// CONFIGURATION
//   IFETCH_LINEBUF_EN defined: one-entry line buffer (valid bit, tag pc[63:3], 64-bit data).
//     Filled on every non-flushed ack.
//     A hit on an aligned accept goes IDLE->RESP with no mem_req_o, so inst_valid_o rises at T+1.
//     Invalidated by rst or fence_i_i. fence_i_i in the same cycle as an accept forces a miss.
//   Not defined: no buffer. Every aligned fetch goes through REQ. fence_i_i is ignored.
// STRUCTURE
//   Shared package: state encoding localparams (IDLE/REQ/DRAIN/RESP), RESET_PC value,
//     word-select helper function.
//   Optional sub-module ysyx_22050133_ifetch_linebuf (tag/data/valid storage plus hit compare),
//     instantiated only under IFETCH_LINEBUF_EN.
// TESTING
//   1. pc_i=0x8000_0004 accepted, ack after 3 cycles with rdata=0x1111_2222_3333_4444
//      -> mem_addr_o=0x8000_0000, inst64_o=0x3333_4444_1111_2222, inst_valid_o held.
//   2. inst_ready_i low for 5 cycles in RESP -> inst64_o stable. pc_ready_o=0 until one cycle after the handshake.
//   3. flush_i in REQ, ack 2 cycles later -> DRAIN; inst_valid_o never rises; pc_ready_o=1 after the ack.
//   4. pc_i=0x8000_0002 -> fault_o=1, inst64_o=0, inst_valid_o at T+1, mem_req_o never asserted.
//   5. rst asserted in REQ, late ack -> outputs zero, IDLE; the late ack is ignored.
//   6. (IFETCH_LINEBUF_EN) fetch 0x8000_0000 then 0x8000_0004 -> second fetch needs no mem_req_o,
//      inst_valid_o at T+1; after fence_i_i the same pc misses.

Source files
------------

// File: rtl/ysyx_22050133_ifetch_resp_pkg.sv
// Shared definitions for the instruction-fetch responder: FSM encoding, reset pc
// and the word-select helper that puts the addressed 32-bit word in [31:0].
package ysyx_22050133_ifetch_resp_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        REQ   = ST_REQ,
        DRAIN = ST_DRAIN,
        RESP  = ST_RESP
    } state_e;

    localparam logic [63:0] IFETCH_RESET_PC = 64'h8000_0000;

    // pc[2] selects the upper word of the doubleword, which is swapped into [31:0].
    function automatic logic [63:0] word_select(input logic hi, input logic [63:0] data);
        return hi ? {data[31:0], data[63:32]} : data;
    endfunction

endpackage

// File: rtl/ysyx_22050133_ifetch_linebuf.sv
// One-entry instruction line buffer (valid, tag pc[63:3], 64-bit data) with hit compare.
// Only built when IFETCH_LINEBUF_EN is defined.
`ifdef IFETCH_LINEBUF_EN
module ysyx_22050133_ifetch_linebuf (
    input  logic        clk,
    input  logic        rst,
    input  logic        fill,
    input  logic [60:0] fill_tag,
    input  logic [63:0] fill_data,
    input  logic        inval,
    input  logic [60:0] lookup_tag,
    output logic        hit,
    output logic [63:0] hit_data
);

    logic        valid_q;
    logic [60:0] tag_q;
    logic [63:0] data_q;

    // Invalidation wins over a fill in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
        end else if (inval) begin
            valid_q <= 1'b0;
        end else if (fill) begin
            valid_q <= 1'b1;
        end
    end

    // NOTE: tag/data need no reset; valid_q alone qualifies them.
    always_ff @(posedge clk) begin
        if (fill) begin
            tag_q  <= fill_tag;
            data_q <= fill_data;
        end
    end

    assign hit      = valid_q && (tag_q == lookup_tag);
    assign hit_data = data_q;

endmodule
`endif

// File: rtl/ysyx_22050133_ifetch_resp.sv
// Instruction-fetch responder: accepts a pc, issues one aligned 64-bit read and returns
// the doubleword with the addressed word in [31:0]. Optional line buffer: IFETCH_LINEBUF_EN.
module ysyx_22050133_ifetch_resp
    import ysyx_22050133_ifetch_resp_pkg::*;
#(
    parameter logic [63:0] RESET_PC = IFETCH_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_valid_i,
    input  logic [63:0] pc_i,
    output logic        pc_ready_o,
    input  logic        flush_i,
    input  logic        fence_i_i,
    output logic        mem_req_o,
    output logic [63:0] mem_addr_o,
    input  logic        mem_ack_i,
    input  logic [63:0] mem_rdata_i,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    output logic [63:0] inst64_o,
    output logic        fault_o,
    output logic [63:0] pc_q_o
);

    state_e      state_q, state_d;
    logic [63:0] pc_q;
    logic [63:0] rdata_q;
    logic        fault_q;
    logic        accept;
    logic        aligned;
    logic        lb_hit;
    logic [63:0] lb_data;

    assign pc_ready_o = (state_q == IDLE) & ~flush_i;
    assign accept     = pc_valid_i & pc_ready_o;
    assign aligned    = (pc_i[1:0] == 2'b00);

`ifdef IFETCH_LINEBUF_EN
    logic lb_raw_hit;
    logic lb_fill;

    // Only a live (non-flushed) fetch may fill the buffer.
    assign lb_fill = (state_q == REQ) & mem_ack_i & ~flush_i;

    ysyx_22050133_ifetch_linebuf u_linebuf (
        .clk        (clk),
        .rst        (rst),
        .fill       (lb_fill),
        .fill_tag   (pc_q[63:3]),
        .fill_data  (mem_rdata_i),
        .inval      (fence_i_i),
        .lookup_tag (pc_i[63:3]),
        .hit        (lb_raw_hit),
        .hit_data   (lb_data)
    );

    assign lb_hit = lb_raw_hit & ~fence_i_i;
`else
    logic unused_fence;

    assign unused_fence = fence_i_i;
    assign lb_hit       = 1'b0;
    assign lb_data      = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = (aligned && !lb_hit) ? REQ : RESP;
                end
            end
            REQ: begin
                if (mem_ack_i) begin
                    state_d = flush_i ? IDLE : RESP;
                end else if (flush_i) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (mem_ack_i) begin
                    state_d = IDLE;
                end
            end
            RESP: begin
                if (flush_i || inst_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its sources.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            rdata_q <= '0;
            fault_q <= 1'b0;
        end else if (accept) begin
            pc_q    <= pc_i;
            fault_q <= ~aligned;
            rdata_q <= lb_data;
        end else if ((state_q == REQ) && mem_ack_i) begin
            rdata_q <= mem_rdata_i;
        end
    end

    assign mem_req_o    = (state_q == REQ) | (state_q == DRAIN);
    assign mem_addr_o   = mem_req_o ? {pc_q[63:3], 3'b000} : '0;
    assign inst_valid_o = (state_q == RESP);
    assign fault_o      = inst_valid_o & fault_q;
    assign inst64_o     = (inst_valid_o & ~fault_q) ? word_select(pc_q[2], rdata_q) : '0;
    assign pc_q_o       = pc_q;

endmodule
